cm_line_sequencer: RTL and testbench
====================================

// Module: cm_line_sequencer
// PURPOSE
//  Frame/line timing controller that sequences CM_Counter. Drives its Sync window and its BackPorch/FrontPorch bounds.
//  Holds a programmable line/frame geometry in shadow registers and applies it only at frame boundaries.
//  Emits line index, frame-done pulse and status to the capture path that consumes CounterP/Counter_Valid.
// PARAMETERS
//  BACKPORCH_WIDTH   8   width of BackPorch bound (matches CM_Width_Parameters.v)
//  FRONTPORCH_WIDTH  11  width of FrontPorch bound and of the active-line length
//  LINE_CNT_WIDTH    10  width of lines-per-frame and line index
//  BLANK_WIDTH       8   width of inter-line blanking length
// PORTS
//  clk           in   1    system clock, rising edge
//  rst_n         in   1    asynchronous active-low reset
//  cfg_wr        in   1    1-cycle strobe: capture cfg_* into pending registers
//  cfg_backporch in   BACKPORCH_WIDTH   pending BackPorch
//  cfg_frontporch in  FRONTPORCH_WIDTH  pending FrontPorch
//  cfg_line_len  in   FRONTPORCH_WIDTH  Sync-high cycles per line (L)
//  cfg_blank     in   BLANK_WIDTH       Sync-low cycles between lines (B)
//  cfg_lines     in   LINE_CNT_WIDTH    lines per frame (N)
//  cfg_continuous in  1    1: restart next frame automatically
//  start         in   1    1-cycle strobe: begin frame (honoured in IDLE only)
//  stop          in   1    1-cycle strobe: finish current frame, then IDLE
//  Sync          out  1    to CM_Counter.Sync
//  BackPorch     out  BACKPORCH_WIDTH   to CM_Counter.BackPorch (active config)
//  FrontPorch    out  FRONTPORCH_WIDTH  to CM_Counter.FrontPorch (active config)
//  line_idx      out  LINE_CNT_WIDTH    current line, 0..N-1
//  frame_done    out  1    1-cycle pulse after last line's blanking
//  busy          out  1    high in any state except IDLE
//  cfg_err       out  1    active config invalid; sticky until valid config applied
// BEHAVIOUR
//  Reset: all outputs 0, pending/active regs 0, stop_req 0, state IDLE. All outputs registered.
//  FSM IDLE -> ACTIVE -> BLANK -> (ACTIVE | DONE); DONE -> ACTIVE (continuous, no stop_req) else IDLE.
//  IDLE: pending copied to active every cycle. start with cfg_err=0 -> ACTIVE next cycle, line_idx=0.
//  ACTIVE: Sync=1 for exactly L cycles, then BLANK.
//  BLANK: Sync=0 for exactly max(B,1) cycles (>=1 so CM_Counter clears). Then line_idx+1 -> ACTIVE,
//    or, if line_idx==N-1, DONE.
//  DONE: one cycle; frame_done=1; Sync=0; pending copied to active and cfg_err re-evaluated here.
//  cfg_err = (FP <= BP+1) | (FP > L) | (L==0) | (N==0), computed on the active config.
//  cfg_err=1: start ignored; from DONE the FSM goes to IDLE regardless of continuous.
//  Expected counter output per line: FP-BP-1 valid pixels; CounterP 1..FP-BP-1, one cycle after the Sync window index.
//  cfg_wr in any state updates pending only. cfg_wr in the DONE cycle lands in pending; it is applied at the next boundary.
//  stop sets stop_req; cleared on entry to IDLE; stop in IDLE is ignored. start and stop in the same cycle: stop wins.
//  Counters and compares: unsigned, full width; no wrap, terminal counts compared with ==.
//  Async reset mid-frame: Sync drops on assertion; FSM to IDLE; no frame_done.
// STRUCTURE
//  Shared package/include (CM_Width_Parameters.v): width params; state encodings IDLE=0, ACTIVE=1, BLANK=2, DONE=3.
//  Sub-module cm_seq_cfg_regs: pending/active shadow registers plus cfg_err compare.
//  The FSM and the L/B/line counters stay in the top module.
//  Bench instantiates CM_Counter downstream of this block.
// TESTING
//  BP=2 FP=7 L=10 B=3 N=2, cont=0, start -> Sync 10 high/3 low x2; frame_done once; 4 valid px/line; CounterP 1..4.
//  Same config, cont=1; stop mid line 1 of frame 2 -> frame 2 completes, frame_done x2, then IDLE, busy=0.
//  B=0 -> Sync low exactly 1 cycle between lines; CounterP resets to 0 each line.
//  FP=3 BP=2 -> cfg_err=1; start ignored; Sync stays 0.
//  Rewrite to valid cfg in IDLE -> cfg_err clears next cycle.
//  cfg_wr BP=1 FP=9 during frame 1 (cont=1) -> frame 1 keeps 4 px/line; frame 2 gives 7 px/line.
//  rst_n low during ACTIVE line 1 -> Sync=0, busy=0, line_idx=0 asynchronously; no frame_done; restart works.

Source files
------------

// File: rtl/cm_line_sequencer_pkg.sv
// Shared widths and FSM state encoding for the CM line sequencer.
package cm_line_sequencer_pkg;

   localparam int CM_BACKPORCH_WIDTH  = 8;
   localparam int CM_FRONTPORCH_WIDTH = 11;
   localparam int CM_LINE_CNT_WIDTH   = 10;
   localparam int CM_BLANK_WIDTH      = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_BLANK  = 2'd2,
      ST_DONE   = 2'd3
   } seq_state_e;

endpackage

// File: rtl/cm_seq_cfg_regs.sv
// Pending/active geometry shadow registers; active config changes only when apply is high,
// and cfg_err is re-evaluated at that same moment.
module cm_seq_cfg_regs #(
   parameter int BACKPORCH_WIDTH  = 8,
   parameter int FRONTPORCH_WIDTH = 11,
   parameter int LINE_CNT_WIDTH   = 10,
   parameter int BLANK_WIDTH      = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cfg_wr,
   input  logic [BACKPORCH_WIDTH-1:0]  cfg_backporch,
   input  logic [FRONTPORCH_WIDTH-1:0] cfg_frontporch,
   input  logic [FRONTPORCH_WIDTH-1:0] cfg_line_len,
   input  logic [BLANK_WIDTH-1:0]      cfg_blank,
   input  logic [LINE_CNT_WIDTH-1:0]   cfg_lines,
   input  logic                        cfg_continuous,
   input  logic                        apply,
   output logic [BACKPORCH_WIDTH-1:0]  act_backporch,
   output logic [FRONTPORCH_WIDTH-1:0] act_frontporch,
   output logic [FRONTPORCH_WIDTH-1:0] act_line_len,
   output logic [BLANK_WIDTH-1:0]      act_blank,
   output logic [LINE_CNT_WIDTH-1:0]   act_lines,
   output logic                        cont_next,
   output logic                        err_next,
   output logic                        cfg_err
);

   localparam int CW = FRONTPORCH_WIDTH + 1;

   logic [BACKPORCH_WIDTH-1:0]  pend_backporch;
   logic [FRONTPORCH_WIDTH-1:0] pend_frontporch;
   logic [FRONTPORCH_WIDTH-1:0] pend_line_len;
   logic [BLANK_WIDTH-1:0]      pend_blank;
   logic [LINE_CNT_WIDTH-1:0]   pend_lines;
   logic                        pend_continuous;
   logic                        act_continuous;
   logic [CW-1:0]               bp_plus1;
   logic                        pend_invalid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_backporch  <= '0;
         pend_frontporch <= '0;
         pend_line_len   <= '0;
         pend_blank      <= '0;
         pend_lines      <= '0;
         pend_continuous <= 1'b0;
      end else if (cfg_wr) begin
         pend_backporch  <= cfg_backporch;
         pend_frontporch <= cfg_frontporch;
         pend_line_len   <= cfg_line_len;
         pend_blank      <= cfg_blank;
         pend_lines      <= cfg_lines;
         pend_continuous <= cfg_continuous;
      end
   end

   // FrontPorch must leave at least one valid pixel after BackPorch and fit inside the Sync window.
   always_comb begin
      bp_plus1     = CW'(pend_backporch) + CW'(1);
      pend_invalid = (CW'(pend_frontporch) <= bp_plus1) ||
                     (pend_frontporch > pend_line_len) ||
                     (pend_line_len == '0) ||
                     (pend_lines == '0);
      err_next     = apply ? pend_invalid : cfg_err;
      cont_next    = apply ? pend_continuous : act_continuous;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_backporch  <= '0;
         act_frontporch <= '0;
         act_line_len   <= '0;
         act_blank      <= '0;
         act_lines      <= '0;
         act_continuous <= 1'b0;
         cfg_err        <= 1'b0;
      end else if (apply) begin
         act_backporch  <= pend_backporch;
         act_frontporch <= pend_frontporch;
         act_line_len   <= pend_line_len;
         act_blank      <= pend_blank;
         act_lines      <= pend_lines;
         act_continuous <= pend_continuous;
         cfg_err        <= pend_invalid;
      end
   end

endmodule

// File: rtl/cm_line_sequencer.sv
// Frame/line timing controller driving CM_Counter's Sync window and porch bounds.
// Valid/ready does not apply here: start, stop and cfg_wr are single-cycle strobes sampled on clk.
module cm_line_sequencer
   import cm_line_sequencer_pkg::*;
#(
   parameter int BACKPORCH_WIDTH  = CM_BACKPORCH_WIDTH,
   parameter int FRONTPORCH_WIDTH = CM_FRONTPORCH_WIDTH,
   parameter int LINE_CNT_WIDTH   = CM_LINE_CNT_WIDTH,
   parameter int BLANK_WIDTH      = CM_BLANK_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cfg_wr,
   input  logic [BACKPORCH_WIDTH-1:0]  cfg_backporch,
   input  logic [FRONTPORCH_WIDTH-1:0] cfg_frontporch,
   input  logic [FRONTPORCH_WIDTH-1:0] cfg_line_len,
   input  logic [BLANK_WIDTH-1:0]      cfg_blank,
   input  logic [LINE_CNT_WIDTH-1:0]   cfg_lines,
   input  logic                        cfg_continuous,
   input  logic                        start,
   input  logic                        stop,
   output logic                        Sync,
   output logic [BACKPORCH_WIDTH-1:0]  BackPorch,
   output logic [FRONTPORCH_WIDTH-1:0] FrontPorch,
   output logic [LINE_CNT_WIDTH-1:0]   line_idx,
   output logic                        frame_done,
   output logic                        busy,
   output logic                        cfg_err,
   output seq_state_e                  dbg_state
);

   localparam int CW = FRONTPORCH_WIDTH + 1;
   localparam int LW = LINE_CNT_WIDTH + 1;

   seq_state_e                  state, state_next;
   logic [FRONTPORCH_WIDTH-1:0] cnt, cnt_next;
   logic [LINE_CNT_WIDTH-1:0]   line_next;
   logic                        stop_req, stop_req_next;
   logic [FRONTPORCH_WIDTH-1:0] act_line_len;
   logic [BLANK_WIDTH-1:0]      act_blank;
   logic [LINE_CNT_WIDTH-1:0]   act_lines;
   logic                        cont_next, err_next, apply;
   logic [CW-1:0]               cnt_inc;
   logic [LW-1:0]               line_inc;
   logic                        line_end, blank_end, frame_end;

   assign apply     = (state == ST_IDLE) || (state == ST_DONE);
   assign dbg_state = state;

   cm_seq_cfg_regs #(
      .BACKPORCH_WIDTH (BACKPORCH_WIDTH),
      .FRONTPORCH_WIDTH(FRONTPORCH_WIDTH),
      .LINE_CNT_WIDTH  (LINE_CNT_WIDTH),
      .BLANK_WIDTH     (BLANK_WIDTH)
   ) u_cfg (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_wr        (cfg_wr),
      .cfg_backporch (cfg_backporch),
      .cfg_frontporch(cfg_frontporch),
      .cfg_line_len  (cfg_line_len),
      .cfg_blank     (cfg_blank),
      .cfg_lines     (cfg_lines),
      .cfg_continuous(cfg_continuous),
      .apply         (apply),
      .act_backporch (BackPorch),
      .act_frontporch(FrontPorch),
      .act_line_len  (act_line_len),
      .act_blank     (act_blank),
      .act_lines     (act_lines),
      .cont_next     (cont_next),
      .err_next      (err_next),
      .cfg_err       (cfg_err)
   );

   // A zero blank length still yields one Sync-low cycle so the downstream counter clears.
   always_comb begin
      cnt_inc   = CW'(cnt) + CW'(1);
      line_inc  = LW'(line_idx) + LW'(1);
      line_end  = (cnt_inc == CW'(act_line_len));
      blank_end = (act_blank == '0) || (cnt_inc == CW'(act_blank));
      frame_end = (line_inc == LW'(act_lines));
   end

   always_comb begin
      state_next    = state;
      cnt_next      = cnt;
      line_next     = line_idx;
      stop_req_next = stop_req;
      case (state)
         ST_IDLE: begin
            cnt_next  = '0;
            line_next = '0;
            if (start && !stop && !err_next) state_next = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (line_end) begin
               state_next = ST_BLANK;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_inc[FRONTPORCH_WIDTH-1:0];
            end
         end
         ST_BLANK: begin
            if (blank_end) begin
               cnt_next = '0;
               if (frame_end) begin
                  state_next = ST_DONE;
               end else begin
                  state_next = ST_ACTIVE;
                  line_next  = line_inc[LINE_CNT_WIDTH-1:0];
               end
            end else begin
               cnt_next = cnt_inc[FRONTPORCH_WIDTH-1:0];
            end
         end
         ST_DONE: begin
            cnt_next  = '0;
            line_next = '0;
            if (cont_next && !err_next && !stop_req && !stop) state_next = ST_ACTIVE;
            else state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
      if (stop && state != ST_IDLE) stop_req_next = 1'b1;
      if (state_next == ST_IDLE) stop_req_next = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         line_idx   <= '0;
         stop_req   <= 1'b0;
         Sync       <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         line_idx   <= line_next;
         stop_req   <= stop_req_next;
         Sync       <= (state_next == ST_ACTIVE);
         busy       <= (state_next != ST_IDLE);
         frame_done <= (state_next == ST_DONE);
      end
   end

endmodule

// File: tb/tb_cm_line_sequencer.sv
// Bench for cm_line_sequencer: per-cycle frame model plus a downstream pixel counter.
module tb_cm_line_sequencer;
   import cm_line_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_wr = 1'b0;
   logic [7:0]  cfg_backporch = '0;
   logic [10:0] cfg_frontporch = '0;
   logic [10:0] cfg_line_len = '0;
   logic [7:0]  cfg_blank = '0;
   logic [9:0]  cfg_lines = '0;
   logic        cfg_continuous = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        Sync;
   logic [7:0]  BackPorch;
   logic [10:0] FrontPorch;
   logic [9:0]  line_idx;
   logic        frame_done, busy, cfg_err;
   seq_state_e  dbg_state;

   int checks = 0;
   int failures = 0;
   logic [12:0] exp_q[$];
   int px_exp_q[$];
   int px_q[$];
   int win = 0;
   int px_cnt = 0;

   cm_line_sequencer dut (
      .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr),
      .cfg_backporch(cfg_backporch), .cfg_frontporch(cfg_frontporch),
      .cfg_line_len(cfg_line_len), .cfg_blank(cfg_blank), .cfg_lines(cfg_lines),
      .cfg_continuous(cfg_continuous), .start(start), .stop(stop),
      .Sync(Sync), .BackPorch(BackPorch), .FrontPorch(FrontPorch),
      .line_idx(line_idx), .frame_done(frame_done), .busy(busy),
      .cfg_err(cfg_err), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Downstream counter: window index counts Sync-high cycles, pixels valid for BackPorch < idx < FrontPorch.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win    <= 0;
         px_cnt <= 0;
      end else if (Sync) begin
         win <= win + 1;
         if ((win + 1) > int'(BackPorch) && (win + 1) < int'(FrontPorch)) px_cnt <= px_cnt + 1;
      end else begin
         if (win != 0) px_q.push_back(px_cnt);
         win    <= 0;
         px_cnt <= 0;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input int bp, input int fp, input int l, input int b, input int n, input logic cont);
      cfg_backporch  = 8'(bp);
      cfg_frontporch = 11'(fp);
      cfg_line_len   = 11'(l);
      cfg_blank      = 8'(b);
      cfg_lines      = 10'(n);
      cfg_continuous = cont;
   endtask

   task automatic write_cfg(input int bp, input int fp, input int l, input int b, input int n, input logic cont);
      set_cfg(bp, fp, l, b, n, cont);
      cfg_wr = 1'b1;
      tick();
      cfg_wr = 1'b0;
   endtask

   task automatic pulse_start;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   function automatic logic [12:0] pack(input bit b, input bit fd, input bit s, input int li);
      return {b, fd, s, 10'(li)};
   endfunction

   // One frame: each line is L Sync-high cycles then max(B,1) low cycles; then one frame_done cycle.
   task automatic model_frame(input int l, input int b, input int n, input int bp, input int fp);
      for (int ln = 0; ln < n; ln++) begin
         repeat (l) exp_q.push_back(pack(1, 0, 1, ln));
         repeat ((b == 0) ? 1 : b) exp_q.push_back(pack(1, 0, 0, ln));
         px_exp_q.push_back(fp - bp - 1);
      end
      exp_q.push_back(pack(1, 1, 0, n - 1));
   endtask

   task automatic model_idle;
      exp_q.push_back(pack(0, 0, 0, 0));
   endtask

   task automatic run_check(input string name, input int stop_at, input int wr_at);
      logic [12:0] exp, obs;
      int k = 0;
      while (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         obs = {busy, frame_done, Sync, line_idx};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got busy=%b done=%b sync=%b line=%0d, want busy=%b done=%b sync=%b line=%0d",
                     name, k, obs[12], obs[11], obs[10], obs[9:0], exp[12], exp[11], exp[10], exp[9:0]);
         end
         stop   = (k == stop_at);
         cfg_wr = (k == wr_at);
         tick();
         k++;
      end
      stop   = 1'b0;
      cfg_wr = 1'b0;
   endtask

   task automatic check_px(input string name);
      int got, want;
      while (px_exp_q.size() > 0) begin
         want = px_exp_q.pop_front();
         checks++;
         if (px_q.size() == 0) begin
            failures++;
            $display("FAIL %s_px: got no line, want %0d pixels", name, want);
         end else begin
            got = px_q.pop_front();
            if (got != want) begin
               failures++;
               $display("FAIL %s_px: got %0d pixels, want %0d", name, got, want);
            end
         end
      end
      checks++;
      if (px_q.size() != 0) begin
         failures++;
         $display("FAIL %s_px_extra: got %0d extra lines, want 0", name, px_q.size());
      end
      px_q.delete();
   endtask

   task automatic check_bit(input string name, input logic got, input logic want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %b, want %b", name, got, want);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if ({Sync, busy, frame_done, cfg_err} !== 4'b0 || line_idx !== '0 || BackPorch !== '0 || FrontPorch !== '0) begin
         failures++;
         $display("FAIL reset: got sync=%b busy=%b done=%b err=%b line=%0d bp=%0d fp=%0d, want all 0",
                  Sync, busy, frame_done, cfg_err, line_idx, BackPorch, FrontPorch);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic;
      write_cfg(2, 7, 10, 3, 2, 1'b0);
      tick();
      check_bit("basic_cfg_err", cfg_err, 1'b0);
      checks++;
      if (BackPorch !== 8'd2 || FrontPorch !== 11'd7) begin
         failures++;
         $display("FAIL basic_porch: got bp=%0d fp=%0d, want bp=2 fp=7", BackPorch, FrontPorch);
      end
      pulse_start();
      model_frame(10, 3, 2, 2, 7);
      model_idle();
      run_check("basic", -1, -1);
      check_px("basic");
   endtask

   task automatic test_continuous_stop;
      write_cfg(2, 7, 10, 3, 2, 1'b1);
      tick();
      pulse_start();
      model_frame(10, 3, 2, 2, 7);
      model_frame(10, 3, 2, 2, 7);
      model_idle();
      run_check("cont_stop", 27 + 13 + 3, -1);
      check_px("cont_stop");
      repeat (3) tick();
      check_bit("cont_stop_idle_busy", busy, 1'b0);
      check_bit("cont_stop_idle_sync", Sync, 1'b0);
   endtask

   task automatic test_blank_zero;
      int l, n;
      l = $urandom_range(8, 12);
      n = $urandom_range(2, 4);
      write_cfg(2, 7, l, 0, n, 1'b0);
      tick();
      pulse_start();
      model_frame(l, 0, n, 2, 7);
      model_idle();
      run_check("blank_zero", -1, -1);
      check_px("blank_zero");
   endtask

   task automatic test_cfg_err;
      write_cfg(2, 3, 10, 3, 2, 1'b0);
      tick();
      check_bit("cfg_err_set", cfg_err, 1'b1);
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         check_bit("cfg_err_sync_low", Sync, 1'b0);
         check_bit("cfg_err_not_busy", busy, 1'b0);
         tick();
      end
   endtask

   task automatic test_cfg_recover;
      write_cfg(2, 7, 10, 3, 2, 1'b0);
      check_bit("recover_still_err", cfg_err, 1'b1);
      tick();
      check_bit("recover_cleared", cfg_err, 1'b0);
   endtask

   task automatic test_start_stop_same;
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      check_bit("start_stop_busy", busy, 1'b0);
      check_bit("start_stop_sync", Sync, 1'b0);
   endtask

   task automatic test_shadow;
      write_cfg(2, 7, 10, 3, 2, 1'b1);
      tick();
      pulse_start();
      set_cfg(1, 9, 10, 3, 2, 1'b1);
      model_frame(10, 3, 2, 2, 7);
      model_frame(10, 3, 2, 1, 9);
      model_idle();
      run_check("shadow", 27 + 13 + 3, 5);
      check_px("shadow");
   endtask

   task automatic test_reset_mid;
      write_cfg(2, 7, 10, 3, 2, 1'b0);
      tick();
      pulse_start();
      repeat (13 + 3) tick();
      checks++;
      if (Sync !== 1'b1 || line_idx !== 10'd1) begin
         failures++;
         $display("FAIL reset_mid_pre: got sync=%b line=%0d, want sync=1 line=1", Sync, line_idx);
      end
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (Sync !== 1'b0 || busy !== 1'b0 || line_idx !== '0 || frame_done !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_async: got sync=%b busy=%b line=%0d done=%b, want 0 0 0 0",
                  Sync, busy, line_idx, frame_done);
      end
      tick();
      check_bit("reset_mid_no_done", frame_done, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      px_q.delete();
      write_cfg(2, 7, 10, 3, 2, 1'b0);
      tick();
      pulse_start();
      model_frame(10, 3, 2, 2, 7);
      model_idle();
      run_check("reset_mid_restart", -1, -1);
      check_px("reset_mid_restart");
   endtask

   task automatic test_random;
      int bp, fp, l, b, n;
      for (int it = 0; it < 4; it++) begin
         bp = $urandom_range(0, 4);
         fp = bp + $urandom_range(2, 6);
         l  = fp + $urandom_range(0, 5);
         b  = $urandom_range(0, 4);
         n  = $urandom_range(1, 3);
         write_cfg(bp, fp, l, b, n, 1'b0);
         tick();
         check_bit("random_cfg_err", cfg_err, 1'b0);
         pulse_start();
         model_frame(l, b, n, bp, fp);
         model_idle();
         run_check("random", -1, -1);
         check_px("random");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_continuous_stop();
      test_blank_zero();
      test_cfg_err();
      test_cfg_recover();
      test_start_stop_same();
      test_shadow();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
